// File: rtl/serial_adder_stream_driver.sv
// Serial-add stream driver: accepts an operand pair, streams it LSB-first with
// vld/last framing to a one-bit serial adder, and returns the collected sum.
module serial_adder_stream_driver #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             pause,
    output logic             ser_vld,
    output logic             ser_a,
    output logic             ser_b,
    output logic             ser_last,
    input  logic             ser_sum,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        ser_vld   = 1'b0;
        ser_a     = 1'b0;
        ser_b     = 1'b0;
        ser_last  = 1'b0;
        res_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = SHIFT;
            end
            SHIFT: begin
                // a paused cycle is a pure bubble: all framing bits stay low
                if (!pause) begin
                    ser_vld  = 1'b1;
                    ser_a    = sh_a[0];
                    ser_b    = sh_b[0];
                    ser_last = (cnt == LAST_CNT);
                    if (cnt == LAST_CNT) state_nxt = HOLD;
                end
            end
            HOLD: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sh_a  <= '0;
            sh_b  <= '0;
            res   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && in_valid) begin
                sh_a <= in_a;
                sh_b <= in_b;
                cnt  <= '0;
            end else if (state == SHIFT && ser_vld) begin
                res[cnt] <= ser_sum;
                sh_a     <= sh_a >> 1;
                sh_b     <= sh_b >> 1;
                cnt      <= cnt + 1'b1;
            end
        end
    end

    assign res_sum = res;

endmodule

// File: tb/tb_serial_adder_stream_driver.sv
// Bench for serial_adder_stream_driver (WIDTH=4) with a behavioural serial adder
// downstream; expected sums are plain modular addition of the operands.
module tb_serial_adder_stream_driver;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         pause = 1'b0;
    logic         ser_vld;
    logic         ser_a;
    logic         ser_b;
    logic         ser_last;
    logic         ser_sum;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] res_sum;

    int errors = 0;
    int checks = 0;

    serial_adder_stream_driver #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .pause(pause),
        .ser_vld(ser_vld), .ser_a(ser_a), .ser_b(ser_b), .ser_last(ser_last),
        .ser_sum(ser_sum),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum)
    );

    always #5 clk = ~clk;

    // downstream one-bit adder; carry clears after the framed last bit
    logic carry;
    assign ser_sum = ser_a ^ ser_b ^ carry;
    always @(posedge clk or posedge rst) begin
        if (rst) carry <= 1'b0;
        else if (ser_vld) carry <= ser_last ? 1'b0 : ((ser_a & ser_b) | (carry & (ser_a ^ ser_b)));
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one full operation; pmask bit c pauses cycle c after the accept edge
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int pmask, input int hold);
        int k;
        int c;
        int npause;
        int exp_sum;
        logic vld_exp;
        exp_sum = (int'(a) + int'(b)) % (1 << W);
        npause = 0;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        #1;
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        k = 0;
        c = 1;
        while (k < W && c < 40) begin
            pause = pmask[c];
            vld_exp = !pause;
            if (pause) npause++;
            #1;
            chk("ser_vld", 32'(ser_vld), 32'(vld_exp));
            chk("busy_in_ready", 32'(in_ready), 32'd0);
            chk("busy_res_valid", 32'(res_valid), 32'd0);
            if (vld_exp) begin
                chk("ser_a", 32'(ser_a), 32'(a[k]));
                chk("ser_b", 32'(ser_b), 32'(b[k]));
                chk("ser_last", 32'(ser_last), 32'(k == W - 1));
            end else begin
                chk("bubble_bits", {29'd0, ser_a, ser_b, ser_last}, 32'd0);
            end
            @(posedge clk); #1;
            if (vld_exp) k++;
            c++;
        end
        pause = 1'b0;
        chk("res_cycle", 32'(c), 32'(W + 1 + npause));
        for (int h = 0; h < hold; h++) begin
            res_ready = 1'b0;
            in_valid = 1'($urandom_range(0, 1));
            pause = 1'($urandom_range(0, 1));
            #1;
            chk("hold_res_valid", 32'(res_valid), 32'd1);
            chk("hold_res_sum", 32'(res_sum), 32'(exp_sum));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_ser_vld", 32'(ser_vld), 32'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        pause = 1'b0;
        res_ready = 1'b1;
        #1;
        chk("res_valid", 32'(res_valid), 32'd1);
        chk("res_sum", 32'(res_sum), 32'(exp_sum));
        @(posedge clk); #1;
        res_ready = 1'b0;
        #1;
        chk("post_res_valid", 32'(res_valid), 32'd0);
        chk("post_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_outs", {27'd0, ser_vld, ser_a, ser_b, ser_last, res_valid}, 32'd0);
        chk("rst_res_sum", 32'(res_sum), 32'd0);
        #11 rst = 1'b0;
        @(posedge clk); #1;

        do_op(4'd5, 4'd3, 0, 0);
        do_op(4'd15, 4'd1, 0, 0);
        do_op(4'd1, 4'd1, 0, 0);
        do_op(4'd6, 4'd7, 32'h14, 0);
        do_op(4'd9, 4'd4, 0, 5);

        // abort after the second bit
        in_a = 4'd10;
        in_b = 4'd5;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #1;
        chk("mid_ser_vld", 32'(ser_vld), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_outs", {27'd0, ser_vld, ser_a, ser_b, ser_last, res_valid}, 32'd0);
        chk("abort_res_sum", 32'(res_sum), 32'd0);
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("abort_no_res", 32'(res_valid), 32'd0);
        end
        do_op(4'd2, 4'd2, 0, 0);

        do_op(4'd3, 4'd4, 0, 0);
        do_op(4'd8, 4'd8, 0, 0);

        for (int i = 0; i < 25; i++) begin
            do_op(4'($urandom), 4'($urandom), int'($urandom) & 32'h3fe,
                  int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
